// File: rtl/capture_buffer_mc.sv
// Multi-channel I/Q capture buffer: addressed host preload (mode 0) or triggered streaming
// capture with pre-trigger history (mode 1). The read port presents samples oldest-first.
module capture_buffer_mc #(
    parameter int CAP_I_BITS        = 16,
    parameter int CAP_Q_BITS        = 16,
    parameter int CAP_BUFFER_LENGTH = 1000,
    parameter int CAP_INDEX_BITS    = 10,
    parameter int CAP_CHANNELS      = 2,
    parameter int CAP_CH_BITS       = 1,
    parameter int CAP_PRE_TRIG      = 100
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         mode,
    input  logic                                         m_axi_cap_wvalid,
    input  logic [CAP_INDEX_BITS-1:0]                    m_axi_cap_waddr,
    input  logic [CAP_CH_BITS-1:0]                       m_axi_cap_wch,
    input  logic [CAP_I_BITS+CAP_Q_BITS-1:0]             m_axi_cap_wdata,
    output logic                                         s_axi_cap_wready,
    output logic                                         s_axi_cap_bvalid,
    output logic                                         s_axi_cap_bresp,
    input  logic                                         m_axi_cap_bready,
    input  logic                                         stream_valid,
    input  logic [CAP_CHANNELS*(CAP_I_BITS+CAP_Q_BITS)-1:0] stream_data,
    input  logic                                         capture_arm,
    input  logic                                         trigger,
    output logic                                         capture_busy,
    output logic                                         capture_done,
    input  logic                                         m_axi_cap_rvalid,
    input  logic [CAP_INDEX_BITS-1:0]                    m_axi_cap_raddr,
    input  logic [CAP_CH_BITS-1:0]                       m_axi_cap_rch,
    output logic                                         s_axi_cap_rready,
    output logic                                         s_axi_cap_rvalid,
    output logic signed [CAP_I_BITS-1:0]                 cap_i,
    output logic signed [CAP_Q_BITS-1:0]                 cap_q,
    input  logic                                         m_axi_cap_rready
);
    // state        | meaning
    // ST_IDLE      | no capture running; host writes and reads allowed
    // ST_ARMED     | recording pre-trigger history, waiting for a qualified trigger
    // ST_TRIGGERED | recording post-trigger samples
    // ST_DONE      | capture complete; start_ptr points at the oldest kept sample

    localparam int W   = CAP_I_BITS + CAP_Q_BITS;
    localparam int IB  = CAP_INDEX_BITS;
    localparam int LEN = CAP_BUFFER_LENGTH;
    localparam int AW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CW  = (CAP_CHANNELS > 1) ? $clog2(CAP_CHANNELS) : 1;

    localparam logic [IB:0]          LEN_X    = (IB+1)'(LEN);
    localparam logic [IB-1:0]        LAST_IDX = (IB)'(LEN - 1);
    localparam logic [IB-1:0]        IDX_ONE  = (IB)'(1);
    localparam logic [IB-1:0]        PRE_X    = (IB)'(CAP_PRE_TRIG);
    localparam logic [IB:0]          POST_TGT = (IB+1)'(LEN - CAP_PRE_TRIG);
    localparam logic [IB:0]          POST_ONE = (IB+1)'(1);
    localparam logic [CAP_CH_BITS:0] CH_X     = (CAP_CH_BITS+1)'(CAP_CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRIGGERED,
        ST_DONE
    } cap_state_t;

    cap_state_t state, state_nxt;

    logic [W-1:0]    mem [CAP_CHANNELS][LEN];

    logic [IB-1:0]   wptr;
    logic [IB-1:0]   start_ptr;
    logic [IB-1:0]   trig_ptr;
    logic [IB-1:0]   pre_cnt;
    logic [IB:0]     post_cnt;
    logic [IB-1:0]   start_ptr_done;

    logic            arm_req;
    logic            idle_or_done;
    logic            post_full;
    logic            stream_we;
    logic            trig_accept;
    logic            host_acc;
    logic            host_in_range;
    logic            rd_acc;
    logic            rd_in_range;
    logic [IB:0]     rd_sum;
    logic [IB-1:0]   rd_phys;
    logic [W-1:0]    rd_word;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign arm_req      = capture_arm & mode;
    assign post_full    = (post_cnt == POST_TGT);
    assign capture_busy = (state == ST_ARMED) || (state == ST_TRIGGERED);
    assign capture_done = (state == ST_DONE);

    // The completing post-trigger sample is the last write; the cycle after it is blocked
    // so the oldest pre-trigger sample is never overwritten before DONE.
    assign stream_we   = !reset && stream_valid &&
                         ((state == ST_ARMED) || ((state == ST_TRIGGERED) && !post_full));
    assign trig_accept = (state == ST_ARMED) && stream_valid && trigger && (pre_cnt == PRE_X);

    assign start_ptr_done = (trig_ptr >= PRE_X) ? (trig_ptr - PRE_X)
                                                : (IB)'({1'b0, trig_ptr} + LEN_X - {1'b0, PRE_X});

    assign s_axi_cap_wready = !reset && !mode && idle_or_done && !s_axi_cap_bvalid;
    assign host_acc         = m_axi_cap_wvalid && s_axi_cap_wready;
    assign host_in_range    = ({1'b0, m_axi_cap_waddr} < LEN_X) && ({1'b0, m_axi_cap_wch} < CH_X);

    assign s_axi_cap_rready = !reset && !capture_busy && (!s_axi_cap_rvalid || m_axi_cap_rready);
    assign rd_acc           = m_axi_cap_rvalid && s_axi_cap_rready;
    assign rd_in_range      = ({1'b0, m_axi_cap_raddr} < LEN_X) && ({1'b0, m_axi_cap_rch} < CH_X);
    assign rd_sum           = {1'b0, start_ptr} + {1'b0, m_axi_cap_raddr};
    assign rd_phys          = (rd_sum >= LEN_X) ? (IB)'(rd_sum - LEN_X) : rd_sum[IB-1:0];
    assign rd_word          = mem[m_axi_cap_rch[CW-1:0]][rd_phys[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm_req) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_accept) begin
                    state_nxt = ST_TRIGGERED;
                end
            end
            ST_TRIGGERED: begin
                if (post_full) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Storage has no reset so captured data survives a reset.
    always_ff @(posedge clk) begin
        if (stream_we) begin
            for (int c = 0; c < CAP_CHANNELS; c++) begin
                mem[c][wptr[AW-1:0]] <= stream_data[c*W +: W];
            end
        end else if (host_acc && host_in_range) begin
            mem[m_axi_cap_wch[CW-1:0]][m_axi_cap_waddr[AW-1:0]] <= m_axi_cap_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr             <= '0;
            start_ptr        <= '0;
            trig_ptr         <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            s_axi_cap_bvalid <= 1'b0;
            s_axi_cap_bresp  <= 1'b0;
            s_axi_cap_rvalid <= 1'b0;
            cap_i            <= '0;
            cap_q            <= '0;
        end else begin
            if (idle_or_done && arm_req) begin
                wptr     <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end

            if (stream_we) begin
                wptr <= (wptr == LAST_IDX) ? '0 : wptr + IDX_ONE;
            end

            if ((state == ST_ARMED) && stream_valid && (pre_cnt != PRE_X)) begin
                pre_cnt <= pre_cnt + IDX_ONE;
            end

            if (trig_accept) begin
                trig_ptr <= wptr;
                post_cnt <= POST_ONE;
            end else if ((state == ST_TRIGGERED) && stream_we) begin
                post_cnt <= post_cnt + POST_ONE;
            end

            if ((state == ST_TRIGGERED) && post_full) begin
                start_ptr <= start_ptr_done;
            end else if (host_acc) begin
                start_ptr <= '0;
            end

            if (host_acc) begin
                s_axi_cap_bvalid <= 1'b1;
                s_axi_cap_bresp  <= !host_in_range;
            end else if (s_axi_cap_bvalid && m_axi_cap_bready) begin
                s_axi_cap_bvalid <= 1'b0;
            end

            if (rd_acc) begin
                s_axi_cap_rvalid <= 1'b1;
                if (rd_in_range) begin
                    cap_i <= rd_word[W-1 -: CAP_I_BITS];
                    cap_q <= rd_word[CAP_Q_BITS-1:0];
                end else begin
                    cap_i <= '0;
                    cap_q <= '0;
                end
            end else if (m_axi_cap_rready) begin
                s_axi_cap_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_buffer_mc.sv
// Bench for capture_buffer_mc: host preload/readback, error responses, backpressure and
// randomized triggered captures compared against a sample-history reference model.
module tb_capture_buffer_mc;
    localparam int IW  = 8;
    localparam int QW  = 8;
    localparam int W   = IW + QW;
    localparam int LEN = 16;
    localparam int IB  = 5;
    localparam int CH  = 2;
    localparam int CHB = 1;
    localparam int PRE = 4;

    logic                 clk;
    logic                 reset;
    logic                 mode;
    logic                 m_axi_cap_wvalid;
    logic [IB-1:0]        m_axi_cap_waddr;
    logic [CHB-1:0]       m_axi_cap_wch;
    logic [W-1:0]         m_axi_cap_wdata;
    logic                 s_axi_cap_wready;
    logic                 s_axi_cap_bvalid;
    logic                 s_axi_cap_bresp;
    logic                 m_axi_cap_bready;
    logic                 stream_valid;
    logic [CH*W-1:0]      stream_data;
    logic                 capture_arm;
    logic                 trigger;
    logic                 capture_busy;
    logic                 capture_done;
    logic                 m_axi_cap_rvalid;
    logic [IB-1:0]        m_axi_cap_raddr;
    logic [CHB-1:0]       m_axi_cap_rch;
    logic                 s_axi_cap_rready;
    logic                 s_axi_cap_rvalid;
    logic signed [IW-1:0] cap_i;
    logic signed [QW-1:0] cap_q;
    logic                 m_axi_cap_rready;

    capture_buffer_mc #(
        .CAP_I_BITS(IW), .CAP_Q_BITS(QW), .CAP_BUFFER_LENGTH(LEN), .CAP_INDEX_BITS(IB),
        .CAP_CHANNELS(CH), .CAP_CH_BITS(CHB), .CAP_PRE_TRIG(PRE)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .m_axi_cap_wvalid(m_axi_cap_wvalid), .m_axi_cap_waddr(m_axi_cap_waddr),
        .m_axi_cap_wch(m_axi_cap_wch), .m_axi_cap_wdata(m_axi_cap_wdata),
        .s_axi_cap_wready(s_axi_cap_wready), .s_axi_cap_bvalid(s_axi_cap_bvalid),
        .s_axi_cap_bresp(s_axi_cap_bresp), .m_axi_cap_bready(m_axi_cap_bready),
        .stream_valid(stream_valid), .stream_data(stream_data),
        .capture_arm(capture_arm), .trigger(trigger),
        .capture_busy(capture_busy), .capture_done(capture_done),
        .m_axi_cap_rvalid(m_axi_cap_rvalid), .m_axi_cap_raddr(m_axi_cap_raddr),
        .m_axi_cap_rch(m_axi_cap_rch), .s_axi_cap_rready(s_axi_cap_rready),
        .s_axi_cap_rvalid(s_axi_cap_rvalid), .cap_i(cap_i), .cap_q(cap_q),
        .m_axi_cap_rready(m_axi_cap_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: host view is a plain addressed array; after a capture the logical view is
    // the window of streamed samples around the accepted trigger.
    logic [W-1:0] mdl_mem   [CH][LEN];
    bit           mdl_known [CH][LEN];
    logic [W-1:0] win       [CH][LEN];
    bit           win_mode;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic forget_all();
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < LEN; a++) mdl_known[c][a] = 1'b0;
        win_mode = 1'b0;
    endtask

    function automatic bit exp_rd(input int ch, input int a, output logic [W-1:0] v);
        v = '0;
        if (a >= LEN) return 1'b1;
        if (win_mode) begin
            v = win[ch][a];
            return 1'b1;
        end
        v = mdl_mem[ch][a];
        return mdl_known[ch][a];
    endfunction

    task automatic host_write(input int ch, input int addr, input logic [W-1:0] data, input int hold);
        int t;
        bit oor;
        oor = (addr >= LEN);
        @(negedge clk);
        m_axi_cap_wvalid = 1'b1;
        m_axi_cap_wch    = CHB'(ch);
        m_axi_cap_waddr  = IB'(addr);
        m_axi_cap_wdata  = data;
        t = 0;
        while (!s_axi_cap_wready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk_eq("wready", 32'(s_axi_cap_wready), 32'd1);
        @(negedge clk);
        m_axi_cap_wvalid = 1'b0;
        chk_eq("bvalid", 32'(s_axi_cap_bvalid), 32'd1);
        chk_eq("bresp", 32'(s_axi_cap_bresp), 32'(oor));
        if (win_mode) forget_all();
        if (!oor) begin
            mdl_mem[ch][addr]   = data;
            mdl_known[ch][addr] = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            chk_eq("wready_hold", 32'(s_axi_cap_wready), 32'd0);
            chk_eq("bvalid_hold", 32'(s_axi_cap_bvalid), 32'd1);
            @(negedge clk);
        end
        m_axi_cap_bready = 1'b1;
        @(negedge clk);
        m_axi_cap_bready = 1'b0;
        chk_eq("bvalid_clr", 32'(s_axi_cap_bvalid), 32'd0);
    endtask

    task automatic read_burst(input int ch, input int n, input bit rnd);
        int addrs[$];
        logic [W-1:0] v;
        bit ok;
        for (int i = 0; i < n; i++) addrs.push_back(rnd ? int'($urandom_range(0, LEN + 3)) : i);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk_eq("rvalid", 32'(s_axi_cap_rvalid), 32'd1);
                ok = exp_rd(ch, addrs[i-1], v);
                if (ok) begin
                    chk_eq("rd_i", {24'd0, cap_i}, {24'd0, v[W-1:QW]});
                    chk_eq("rd_q", {24'd0, cap_q}, {24'd0, v[QW-1:0]});
                end
            end
            if (i < n) begin
                chk_eq("rready", 32'(s_axi_cap_rready), 32'd1);
                m_axi_cap_rvalid = 1'b1;
                m_axi_cap_raddr  = IB'(addrs[i]);
                m_axi_cap_rch    = CHB'(ch);
            end else begin
                m_axi_cap_rvalid = 1'b0;
            end
        end
    endtask

    task automatic run_capture(input int trig_a, input int trig_b, input bit rnd);
        logic [CH*W-1:0] smp[$];
        logic [CH*W-1:0] w;
        int cnt, trig_idx, wait_after;
        bit finished, sv, tr;
        cnt = 0; trig_idx = -1; finished = 1'b0; wait_after = 0;
        @(negedge clk);
        mode = 1'b1;
        capture_arm = 1'b1;
        @(negedge clk);
        capture_arm = 1'b0;
        chk_eq("busy_arm", 32'(capture_busy), 32'd1);
        chk_eq("done_arm", 32'(capture_done), 32'd0);
        chk_eq("rready_busy", 32'(s_axi_cap_rready), 32'd0);
        for (int cyc = 0; cyc < 400 && !capture_done; cyc++) begin
            sv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tr = rnd ? ($urandom_range(0, 4) == 0) : (cnt == trig_a || cnt == trig_b);
            stream_valid = sv;
            trigger      = tr;
            stream_data  = {16'($urandom), 8'(cnt), 8'($urandom)};
            if (finished) wait_after++;
            if (sv && !finished) begin
                if (trig_idx < 0 && tr && cnt >= PRE) trig_idx = cnt;
                smp.push_back(stream_data);
                cnt++;
                if (trig_idx >= 0 && cnt == trig_idx + LEN - PRE) finished = 1'b1;
            end
            @(negedge clk);
        end
        stream_valid = 1'b0;
        trigger      = 1'b0;
        chk_eq("cap_done", 32'(capture_done), 32'd1);
        chk_eq("cap_busy_end", 32'(capture_busy), 32'd0);
        chk_eq("done_timing", 32'(finished && wait_after <= 1), 32'd1);
        if (finished) begin
            for (int k = 0; k < LEN; k++) begin
                w = smp[trig_idx - PRE + k];
                win[0][k] = w[W-1:0];
                win[1][k] = w[2*W-1:W];
            end
            win_mode = 1'b1;
        end else begin
            forget_all();
        end
    endtask

    task automatic simul_wr_rd();
        logic [W-1:0] v_old;
        logic [W-1:0] v_new;
        bit ok;
        ok = exp_rd(0, 3, v_old);
        v_new = ~v_old;
        @(negedge clk);
        mode = 1'b0;
        m_axi_cap_wvalid = 1'b1; m_axi_cap_wch = 1'b0; m_axi_cap_waddr = IB'(3); m_axi_cap_wdata = v_new;
        m_axi_cap_rvalid = 1'b1; m_axi_cap_rch = 1'b0; m_axi_cap_raddr = IB'(3);
        chk_eq("sim_wready", 32'(s_axi_cap_wready), 32'd1);
        chk_eq("sim_rready", 32'(s_axi_cap_rready), 32'd1);
        @(negedge clk);
        m_axi_cap_wvalid = 1'b0;
        m_axi_cap_rvalid = 1'b0;
        if (ok) chk_eq("sim_old", {16'd0, cap_i, cap_q}, {16'd0, v_old});
        chk_eq("sim_bvalid", 32'(s_axi_cap_bvalid), 32'd1);
        mdl_mem[0][3]   = v_new;
        mdl_known[0][3] = 1'b1;
        m_axi_cap_bready = 1'b1;
        @(negedge clk);
        m_axi_cap_bready = 1'b0;
    endtask

    task automatic backpressure(input int a);
        logic [W-1:0] v;
        bit ok;
        ok = exp_rd(0, a, v);
        @(negedge clk);
        m_axi_cap_rready = 1'b0;
        m_axi_cap_rvalid = 1'b1; m_axi_cap_rch = 1'b0; m_axi_cap_raddr = IB'(a);
        @(negedge clk);
        m_axi_cap_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_eq("bp_rvalid", 32'(s_axi_cap_rvalid), 32'd1);
            if (ok) chk_eq("bp_data", {16'd0, cap_i, cap_q}, {16'd0, v});
            if (i > 0) chk_eq("bp_rready", 32'(s_axi_cap_rready), 32'd0);
            if (i < 3) @(negedge clk);
        end
        m_axi_cap_rready = 1'b1;
        @(negedge clk);
        chk_eq("bp_release", 32'(s_axi_cap_rvalid), 32'd0);
    endtask

    task automatic reset_mid_capture();
        @(negedge clk);
        mode = 1'b1;
        capture_arm = 1'b1;
        @(negedge clk);
        capture_arm = 1'b0;
        for (int i = 0; i < PRE + 3; i++) begin
            stream_valid = 1'b1;
            trigger      = (i == PRE);
            stream_data  = {16'($urandom), 16'($urandom)};
            @(negedge clk);
        end
        stream_valid = 1'b0;
        trigger      = 1'b0;
        chk_eq("rst_pre_busy", 32'(capture_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("rst_busy", 32'(capture_busy), 32'd0);
        chk_eq("rst_done", 32'(capture_done), 32'd0);
        forget_all();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0;
        m_axi_cap_wvalid = 1'b0; m_axi_cap_waddr = '0; m_axi_cap_wch = '0; m_axi_cap_wdata = '0;
        m_axi_cap_bready = 1'b0; stream_valid = 1'b0; stream_data = '0;
        capture_arm = 1'b0; trigger = 1'b0;
        m_axi_cap_rvalid = 1'b0; m_axi_cap_raddr = '0; m_axi_cap_rch = '0; m_axi_cap_rready = 1'b1;
        forget_all();
        repeat (3) @(negedge clk);
        chk_eq("rst_o_busy", 32'(capture_busy), 32'd0);
        chk_eq("rst_o_done", 32'(capture_done), 32'd0);
        chk_eq("rst_o_wready", 32'(s_axi_cap_wready), 32'd0);
        chk_eq("rst_o_bvalid", 32'(s_axi_cap_bvalid), 32'd0);
        chk_eq("rst_o_bresp", 32'(s_axi_cap_bresp), 32'd0);
        chk_eq("rst_o_rready", 32'(s_axi_cap_rready), 32'd0);
        chk_eq("rst_o_rvalid", 32'(s_axi_cap_rvalid), 32'd0);
        chk_eq("rst_o_data", {16'd0, cap_i, cap_q}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < LEN; k++) begin
            host_write(0, k, {8'(k), 8'(-k)}, (k == 5) ? 2 : 0);
            host_write(1, k, 16'($urandom), 0);
        end
        read_burst(0, LEN, 1'b0);
        read_burst(1, LEN, 1'b0);

        host_write(0, LEN, 16'hABCD, 3);
        read_burst(0, LEN, 1'b0);
        read_burst(1, 10, 1'b1);

        simul_wr_rd();
        read_burst(0, LEN, 1'b0);
        backpressure(7);

        run_capture(2, 10, 1'b0);
        read_burst(0, LEN, 1'b0);
        read_burst(1, LEN, 1'b0);

        run_capture(30, -1, 1'b0);
        read_burst(0, LEN, 1'b0);
        read_burst(1, LEN, 1'b0);

        reset_mid_capture();
        run_capture(-1, -1, 1'b1);
        read_burst(0, LEN, 1'b0);
        read_burst(1, LEN, 1'b0);

        for (int r = 0; r < 3; r++) begin
            run_capture(-1, -1, 1'b1);
            read_burst(0, LEN, 1'b1);
            read_burst(1, LEN, 1'b1);
        end

        mode = 1'b0;
        for (int r = 0; r < 8; r++) begin
            host_write(int'($urandom_range(0, 1)), int'($urandom_range(0, LEN + 2)), 16'($urandom),
                       int'($urandom_range(0, 2)));
        end
        read_burst(0, LEN, 1'b0);
        read_burst(1, LEN, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
